ex_hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage pipeline. Sequences the EX stage and its neighbours.
- Compares the instruction in ID against the in-flight EX and MEM instructions, and selects forwarding sources for the ID operand muxes (EX combinational result or MEM-stage result).
- Selects the flag source for conditional branches.
- Runs a stall FSM that freezes PC/IF-ID and injects a bubble into EX on load-use hazards. Also honours an external freeze.
- Keeps saturating stall and bubble performance counters.

---
 rtl/ex_ctrl_pkg.sv | 28 ++
 rtl/sat_counter.sv | 23 ++
 rtl/ex_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_ex_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_ctrl_pkg.sv
// Shared types and helpers for the EX-stage hazard/forwarding controller.
package ex_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FROZEN   = 2'd2
  } hz_state_t;

  localparam logic [4:0] ZR_IDX = 5'd31;

  // Operand source select: the youngest producer (EX) wins over MEM.
  function automatic fwd_sel_t fwd_sel(input logic uses, input logic m_ex,
                                       input logic m_mem);
    fwd_sel_t s;
    s = FWD_RF;
    if (uses && m_ex)       s = FWD_EX;
    else if (uses && m_mem) s = FWD_MEM;
    return s;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Count enabled cycles; hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset)
      r_count <= '0;
    else if (inc && (r_count != {W{1'b1}}))
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
  end

  assign count = r_count;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Hazard and forwarding controller: operand/flag forwarding selects,
// load-use stall FSM with external freeze, and stall/bubble perf counters.
module ex_hazard_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int         CNT_W = 32,
  parameter logic [4:0] ZR    = ZR_IDX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_reads_flags,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_flag_en,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             freeze,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             ex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_flags,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [1:0]       state_o
);

  hz_state_t r_state;

  logic w_ex_rn, w_ex_rm, w_mem_rn, w_mem_rm;
  logic w_lu, w_bubble, w_stall;

  // The zero register is a sink: writes to it never produce a hazard.
  assign w_ex_rn  = ex_reg_write  && (ex_rd  == id_rn) && (id_rn != ZR);
  assign w_ex_rm  = ex_reg_write  && (ex_rd  == id_rm) && (id_rm != ZR);
  assign w_mem_rn = mem_reg_write && (mem_rd == id_rn) && (id_rn != ZR);
  assign w_mem_rm = mem_reg_write && (mem_rd == id_rm) && (id_rm != ZR);

  // A load result is not available until MEM, so a dependent ID op must wait.
  assign w_lu = id_valid && ex_mem_read &&
                ((id_uses_rn && w_ex_rn) || (id_uses_rm && w_ex_rm));

  // Stall/bubble decision; freeze holds everything without a bubble.
  always_comb begin
    w_bubble = 1'b0;
    if (!reset && !freeze)
      w_bubble = ((r_state == RUN) && w_lu) || (r_state == LU_STALL);
  end

  assign w_stall    = !reset && (freeze || w_bubble);
  assign stall_pc   = w_stall;
  assign stall_ifid = w_stall;
  assign ex_bubble  = w_bubble;

  // Forwarding selects and flag source, all quiet while reset or no ID op.
  always_comb begin
    fwd_a     = FWD_RF;
    fwd_b     = FWD_RF;
    fwd_flags = 1'b0;
    if (!reset && id_valid) begin
      fwd_a     = fwd_sel(id_uses_rn, w_ex_rn, w_mem_rn);
      fwd_b     = fwd_sel(id_uses_rm, w_ex_rm, w_mem_rm);
      fwd_flags = ex_flag_en && id_reads_flags;
    end
  end

  // Stall FSM: one-cycle load-use stall, freeze takes precedence everywhere.
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= RUN;
    else begin
      case (r_state)
        RUN: begin
          if (freeze)    r_state <= FROZEN;
          else if (w_lu) r_state <= LU_STALL;
        end
        LU_STALL: r_state <= freeze ? FROZEN : RUN;
        FROZEN:   r_state <= freeze ? FROZEN : RUN;
        default:  r_state <= RUN;
      endcase
    end
  end

  assign state_o = r_state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_bubble),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl (narrow counters to reach saturation).
module tb_ex_hazard_ctrl;

  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, id_valid, id_uses_rn, id_uses_rm, id_reads_flags;
  logic [4:0]    id_rn, id_rm, ex_rd, mem_rd;
  logic          ex_reg_write, ex_mem_read, ex_flag_en, mem_reg_write, freeze;
  logic          stall_pc, stall_ifid, ex_bubble, fwd_flags;
  logic [1:0]    fwd_a, fwd_b, state_o;
  logic [CW-1:0] stall_cnt, bubble_cnt;

  ex_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_reads_flags(id_reads_flags),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_flag_en(ex_flag_en), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .freeze(freeze), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .ex_bubble(ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_flags(fwd_flags),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .state_o(state_o)
  );

  typedef struct packed {
    logic       reset, id_valid;
    logic [4:0] id_rn, id_rm;
    logic       id_uses_rn, id_uses_rm, id_reads_flags;
    logic [4:0] ex_rd;
    logic       ex_reg_write, ex_mem_read, ex_flag_en;
    logic [4:0] mem_rd;
    logic       mem_reg_write, freeze;
  } in_t;

  typedef struct packed {
    logic          stall_pc, stall_ifid, ex_bubble;
    logic [1:0]    fwd_a, fwd_b;
    logic          fwd_flags;
    logic [1:0]    state;
    logic [CW-1:0] scnt, bcnt;
  } obs_t;

  obs_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [CW-1:0] m_scnt = '0;
  logic [CW-1:0] m_bcnt = '0;

  function automatic in_t lu_in();
    in_t s = '0;
    s.id_valid = 1'b1; s.id_rn = 5'd7; s.id_uses_rn = 1'b1;
    s.ex_rd = 5'd7; s.ex_reg_write = 1'b1; s.ex_mem_read = 1'b1;
    return s;
  endfunction

  function automatic obs_t E(logic st, logic bb, logic [1:0] fa, logic [1:0] fb,
                             logic ff, logic [1:0] stt);
    obs_t o = '0;
    o.stall_pc = st; o.stall_ifid = st; o.ex_bubble = bb;
    o.fwd_a = fa; o.fwd_b = fb; o.fwd_flags = ff; o.state = stt;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.stall_pc = stall_pc; o.stall_ifid = stall_ifid; o.ex_bubble = ex_bubble;
    o.fwd_a = fwd_a; o.fwd_b = fwd_b; o.fwd_flags = fwd_flags; o.state = state_o;
    o.scnt = stall_cnt; o.bcnt = bubble_cnt;
    return o;
  endfunction

  task automatic apply(input in_t s);
    reset = s.reset; id_valid = s.id_valid; id_rn = s.id_rn; id_rm = s.id_rm;
    id_uses_rn = s.id_uses_rn; id_uses_rm = s.id_uses_rm;
    id_reads_flags = s.id_reads_flags; ex_rd = s.ex_rd;
    ex_reg_write = s.ex_reg_write; ex_mem_read = s.ex_mem_read;
    ex_flag_en = s.ex_flag_en; mem_rd = s.mem_rd;
    mem_reg_write = s.mem_reg_write; freeze = s.freeze;
  endtask

  // Producer side: fills in counter values expected this cycle, then
  // advances the counter model by what the coming edge should do.
  task automatic push_exp(input in_t s, input obs_t x);
    x.scnt = m_scnt; x.bcnt = m_bcnt;
    sb.push_back(x);
    if (s.reset) begin
      m_scnt = '0; m_bcnt = '0;
    end else begin
      if (x.stall_pc  && m_scnt != {CW{1'b1}}) m_scnt = m_scnt + 1'b1;
      if (x.ex_bubble && m_bcnt != {CW{1'b1}}) m_bcnt = m_bcnt + 1'b1;
    end
  endtask

  task automatic test_reset();
    in_t s[$]; obs_t x[$]; in_t t; obs_t e, got;
    t = lu_in(); t.reset = 1'b1; t.freeze = 1'b1;
    s.push_back(t); x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd0));
    t = '0;
    s.push_back(t); x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd0));
    foreach (s[i]) begin
      apply(s[i]); push_exp(s[i], x[i]);
      @(negedge clk); got = sample(); e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL reset[%0d] got %h expected %h", i, got, e);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fwd_ex();
    in_t s[$]; obs_t x[$]; in_t t; obs_t e, got;
    t = '0; t.id_valid = 1; t.id_rn = 5'd3; t.id_uses_rn = 1;
    t.ex_rd = 5'd3; t.ex_reg_write = 1;
    s.push_back(t); x.push_back(E(0, 0, 2'b01, 2'b00, 0, 2'd0));
    t.mem_rd = 5'd3; t.mem_reg_write = 1;
    s.push_back(t); x.push_back(E(0, 0, 2'b01, 2'b00, 0, 2'd0));
    t.ex_reg_write = 0;
    s.push_back(t); x.push_back(E(0, 0, 2'b10, 2'b00, 0, 2'd0));
    t.id_valid = 0;
    s.push_back(t); x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd0));
    t.id_valid = 1; t.id_uses_rn = 0;
    s.push_back(t); x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd0));
    foreach (s[i]) begin
      apply(s[i]); push_exp(s[i], x[i]);
      @(negedge clk); got = sample(); e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL fwd_ex[%0d] got %h expected %h", i, got, e);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fwd_mem_zr();
    in_t s[$]; obs_t x[$]; in_t t; obs_t e, got;
    t = '0; t.id_valid = 1; t.id_rm = 5'd5; t.id_uses_rm = 1;
    t.mem_rd = 5'd5; t.mem_reg_write = 1;
    s.push_back(t); x.push_back(E(0, 0, 2'b00, 2'b10, 0, 2'd0));
    t.id_rm = 5'd31; t.ex_rd = 5'd31; t.ex_reg_write = 1; t.mem_rd = 5'd31;
    s.push_back(t); x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd0));
    t = '0; t.id_valid = 1; t.id_rn = 5'd31; t.id_uses_rn = 1;
    t.ex_rd = 5'd31; t.ex_reg_write = 1; t.ex_mem_read = 1;
    s.push_back(t); x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd0));
    t = '0; t.id_valid = 1; t.id_rn = 5'd4; t.id_rm = 5'd6;
    t.id_uses_rn = 1; t.id_uses_rm = 1; t.ex_rd = 5'd6; t.ex_reg_write = 1;
    t.mem_rd = 5'd4; t.mem_reg_write = 1;
    s.push_back(t); x.push_back(E(0, 0, 2'b10, 2'b01, 0, 2'd0));
    foreach (s[i]) begin
      apply(s[i]); push_exp(s[i], x[i]);
      @(negedge clk); got = sample(); e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL fwd_mem_zr[%0d] got %h expected %h", i, got, e);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flags();
    in_t s[$]; obs_t x[$]; in_t t; obs_t e, got;
    t = '0; t.id_valid = 1; t.id_reads_flags = 1; t.ex_flag_en = 1;
    s.push_back(t); x.push_back(E(0, 0, 2'b00, 2'b00, 1, 2'd0));
    t.ex_flag_en = 0;
    s.push_back(t); x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd0));
    t.ex_flag_en = 1; t.id_valid = 0;
    s.push_back(t); x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd0));
    foreach (s[i]) begin
      apply(s[i]); push_exp(s[i], x[i]);
      @(negedge clk); got = sample(); e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL flags[%0d] got %h expected %h", i, got, e);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    in_t s[$]; obs_t x[$]; in_t t; obs_t e, got;
    s.push_back(lu_in()); x.push_back(E(1, 1, 2'b01, 2'b00, 0, 2'd0));
    t = '0; t.id_valid = 1; t.id_rn = 5'd7; t.id_uses_rn = 1;
    t.mem_rd = 5'd7; t.mem_reg_write = 1;
    s.push_back(t); x.push_back(E(1, 1, 2'b10, 2'b00, 0, 2'd1));
    s.push_back(t); x.push_back(E(0, 0, 2'b10, 2'b00, 0, 2'd0));
    // hazard held through the stall cycle must not extend it
    s.push_back(lu_in()); x.push_back(E(1, 1, 2'b01, 2'b00, 0, 2'd0));
    s.push_back(lu_in()); x.push_back(E(1, 1, 2'b01, 2'b00, 0, 2'd1));
    s.push_back(lu_in()); x.push_back(E(1, 1, 2'b01, 2'b00, 0, 2'd0));
    t = '0;
    s.push_back(t); x.push_back(E(1, 1, 2'b00, 2'b00, 0, 2'd1));
    s.push_back(t); x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd0));
    foreach (s[i]) begin
      apply(s[i]); push_exp(s[i], x[i]);
      @(negedge clk); got = sample(); e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL load_use[%0d] got %h expected %h", i, got, e);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_freeze();
    in_t s[$]; obs_t x[$]; in_t t; obs_t e, got;
    t = lu_in(); t.freeze = 1;
    s.push_back(t); x.push_back(E(1, 0, 2'b01, 2'b00, 0, 2'd0));
    s.push_back(t); x.push_back(E(1, 0, 2'b01, 2'b00, 0, 2'd2));
    s.push_back(t); x.push_back(E(1, 0, 2'b01, 2'b00, 0, 2'd2));
    s.push_back(lu_in()); x.push_back(E(0, 0, 2'b01, 2'b00, 0, 2'd2));
    s.push_back(lu_in()); x.push_back(E(1, 1, 2'b01, 2'b00, 0, 2'd0));
    s.push_back(lu_in()); x.push_back(E(1, 1, 2'b01, 2'b00, 0, 2'd1));
    s.push_back('0);      x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd0));
    // freeze arriving during the stall cycle
    s.push_back(lu_in()); x.push_back(E(1, 1, 2'b01, 2'b00, 0, 2'd0));
    s.push_back(t);       x.push_back(E(1, 0, 2'b01, 2'b00, 0, 2'd1));
    s.push_back('0);      x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd2));
    s.push_back('0);      x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd0));
    foreach (s[i]) begin
      apply(s[i]); push_exp(s[i], x[i]);
      @(negedge clk); got = sample(); e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL freeze[%0d] got %h expected %h", i, got, e);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    in_t s[$]; obs_t x[$]; in_t t; obs_t e, got;
    s.push_back(lu_in()); x.push_back(E(1, 1, 2'b01, 2'b00, 0, 2'd0));
    t = lu_in(); t.reset = 1;
    s.push_back(t); x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd1));
    s.push_back('0); x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd0));
    t = '0; t.freeze = 1;
    s.push_back(t); x.push_back(E(1, 0, 2'b00, 2'b00, 0, 2'd0));
    s.push_back(t); x.push_back(E(1, 0, 2'b00, 2'b00, 0, 2'd2));
    t.reset = 1;
    s.push_back(t); x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd2));
    s.push_back('0); x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd0));
    foreach (s[i]) begin
      apply(s[i]); push_exp(s[i], x[i]);
      @(negedge clk); got = sample(); e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL reset_mid[%0d] got %h expected %h", i, got, e);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    in_t s[$]; obs_t x[$]; in_t t; obs_t e, got;
    t = '0; t.freeze = 1;
    for (int k = 0; k < 18; k++) begin
      s.push_back(t); x.push_back(E(1, 0, 2'b00, 2'b00, 0, (k == 0) ? 2'd0 : 2'd2));
    end
    s.push_back('0); x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd2));
    for (int k = 0; k < 9; k++) begin
      s.push_back(lu_in()); x.push_back(E(1, 1, 2'b01, 2'b00, 0, 2'd0));
      s.push_back('0);      x.push_back(E(1, 1, 2'b00, 2'b00, 0, 2'd1));
    end
    s.push_back('0); x.push_back(E(0, 0, 2'b00, 2'b00, 0, 2'd0));
    foreach (s[i]) begin
      apply(s[i]); push_exp(s[i], x[i]);
      @(negedge clk); got = sample(); e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL saturation[%0d] got %h expected %h", i, got, e);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (stall_cnt !== {CW{1'b1}} || bubble_cnt !== {CW{1'b1}})
      $display("FAIL sat_final got %h/%h expected %h/%h", stall_cnt, bubble_cnt,
               {CW{1'b1}}, {CW{1'b1}});
    else n_pass++;
  endtask

  initial begin
    apply('0);
    reset = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_fwd_ex();
    test_fwd_mem_zr();
    test_flags();
    test_load_use();
    test_freeze();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
